// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serdes transmit controller.
package serdes_pkg;

  localparam int SERDES_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/serdes_tx_ctrl_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted index,
// requester 0 is on top after reset. Pointer moves only on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] idx;
  logic          hit;

  // Scan from the pointer, wrapping, and pick the first active request
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = IW'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

  // Priority pointer: step past the winner when the grant is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= '0;
    else if (advance && hit) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/serdes_tx_ctrl.sv
// Serdes transmit controller: arbitrates requesters, loads the serdes with
// one word per frame and sequences start / shift / optional inter-frame gap.
// Optional feature: define SERDES_TX_CTRL_GAP_EN to insert GAP_CYCLES idle
// cycles after every completed frame.
module serdes_tx_ctrl
  import serdes_pkg::*;
#(
  parameter int SERDES_WIDTH = SERDES_WIDTH_DEF,
  parameter int NUM_REQ      = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SERDES_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          abort,
  output logic [SERDES_WIDTH-1:0]       ser_parallel_in,
  output logic                          ser_start,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx_abort,
  output logic [$clog2(NUM_REQ)-1:0]    tx_id
);

  localparam int CW = (SERDES_WIDTH > 1) ? $clog2(SERDES_WIDTH) : 1;
  localparam int IW = $clog2(NUM_REQ);

  tx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]     gidx;
  logic              take;

  assign take = (state == IDLE) && (|req_valid);
  assign busy = (state != IDLE);
  // Gated by rst_n so no accept pulse leaks out while reset is held
  assign req_ready = (take && rst_n) ? grant : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (take),
    .grant   (grant)
  );

  // One-hot grant to index for the data mux and tx_id
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = IW'(i);
  end

`ifdef SERDES_TX_CTRL_GAP_EN
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam tx_state_t DONE_NXT = (GAP_CYCLES > 0) ? GAP : IDLE;
  logic [GW-1:0] gap_cnt;

  // Gap counter runs only while in GAP and clears on every other state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             gap_cnt <= '0;
    else if (state == GAP)  gap_cnt <= gap_cnt + 1'b1;
    else                    gap_cnt <= '0;
  end
`else
  localparam tx_state_t DONE_NXT = IDLE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and frame pulses; abort beats done on the last shift cycle
  always_comb begin
    state_nxt = state;
    ser_start = 1'b0;
    tx_done   = 1'b0;
    tx_abort  = 1'b0;
    case (state)
      IDLE:  if (|req_valid) state_nxt = LOAD;
      LOAD: begin
        ser_start = 1'b1;
        if (abort) begin
          tx_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          tx_abort  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          tx_done   = 1'b1;
          state_nxt = DONE_NXT;
        end
      end
      GAP: begin
`ifdef SERDES_TX_CTRL_GAP_EN
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter: loaded in LOAD, counts down through SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (state == LOAD)              cnt <= CW'(SERDES_WIDTH - 1);
    else if (state == SHIFT && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Word and owner latch at grant; held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_parallel_in <= '0;
      tx_id           <= '0;
    end else if (take) begin
      ser_parallel_in <= req_data[gidx*SERDES_WIDTH +: SERDES_WIDTH];
      tx_id           <= gidx;
    end
  end

endmodule

// File: tb/tb_serdes_tx_ctrl.sv
// Scoreboard bench for serdes_tx_ctrl: stimulus pushes expected events with
// their cycle stamps; a negedge monitor pops and checks them as the DUT
// raises req_ready / ser_start / tx_done / tx_abort. A small serdes model
// shifts ser_parallel_in out MSB first to check the serial stream.
module tb_serdes_tx_ctrl;

  localparam int W = 16;
  localparam int N = 2;
`ifdef SERDES_TX_CTRL_GAP_EN
  localparam int GAPC = 2;
`else
  localparam int GAPC = 0;
`endif
  localparam int SP = W + 2 + GAPC;

  typedef enum int {EV_GRANT = 0, EV_START = 1, EV_DONE = 2, EV_ABORT = 3} ev_kind_t;
  typedef struct {
    ev_kind_t     kind;
    int           cyc;
    logic [N-1:0] mask;
    logic [W-1:0] data;
    int           id;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           abort;
  logic [W-1:0]   ser_parallel_in;
  logic           ser_start, busy, tx_done, tx_abort;
  logic [0:0]     tx_id;

  serdes_tx_ctrl #(.SERDES_WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .abort           (abort),
    .ser_parallel_in (ser_parallel_in),
    .ser_start       (ser_start),
    .busy            (busy),
    .tx_done         (tx_done),
    .tx_abort        (tx_abort),
    .tx_id           (tx_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t q[$];
  int total = 0, bad = 0;

  logic [W-1:0] cur_word;
  logic         in_frame = 1'b0, unstable = 1'b0;
  int           gcyc = 0, idle_chk = -1;
  logic         sd_act = 1'b0, sd_done_now = 1'b0;
  int           sd_cnt = 0;
  logic [W-1:0] sd_stream = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(ev_kind_t k, int c, logic [N-1:0] m, logic [W-1:0] d, int id);
    ev_t e;
    e.kind = k; e.cyc = c; e.mask = m; e.data = d; e.id = id;
    q.push_back(e);
  endfunction

  function automatic void push_frame(int c, int id, logic [W-1:0] d);
    logic [N-1:0] m;
    m = '0;
    m[id] = 1'b1;
    push(EV_GRANT, c, m, d, id);
    push(EV_START, c + 1, m, d, id);
    push(EV_DONE, c + W + 1, m, d, id);
  endfunction

  task automatic take(ev_kind_t k);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d want none (cyc %0d)", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_cycle", cyc, e.cyc);
      case (k)
        EV_GRANT: begin
          chk("req_ready", 32'(req_ready), 32'(e.mask));
          chk("ready_only_idle", 32'(busy), 0);
          cur_word = e.data; in_frame = 1'b1; unstable = 1'b0; gcyc = cyc;
        end
        EV_START: chk("busy_in_load", 32'(busy), 1);
        EV_DONE: begin
          chk("done_tx_id", 32'(tx_id), e.id);
          chk("done_word", 32'(ser_parallel_in), 32'(e.data));
          chk("word_stable", 32'(unstable), 0);
          chk("serial_done_aligned", 32'(sd_done_now), 1);
          chk("serial_stream", 32'(sd_stream), 32'(e.data));
          in_frame = 1'b0;
        end
        EV_ABORT: begin
          chk("abort_tx_id", 32'(tx_id), e.id);
          chk("abort_no_done", 32'(tx_done), 0);
          idle_chk = cyc + 1; in_frame = 1'b0; sd_act = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: serdes model step, stability watch, then event checks
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      sd_done_now = 1'b0;
      if (sd_act) begin
        sd_stream = {sd_stream[W-2:0], ser_parallel_in[sd_cnt]};
        if (sd_cnt == 0) begin sd_done_now = 1'b1; sd_act = 1'b0; end
        else sd_cnt--;
      end
      if (in_frame && cyc > gcyc && ser_parallel_in !== cur_word) unstable = 1'b1;
      if (idle_chk == cyc) chk("idle_after_abort", 32'(busy), 0);
      if (req_ready != '0) take(EV_GRANT);
      if (ser_start) begin
        take(EV_START);
        sd_act = 1'b1; sd_cnt = W - 1; sd_stream = '0;
      end
      if (tx_done)  take(EV_DONE);
      if (tx_abort) take(EV_ABORT);
    end
  end

  task automatic at_cyc(int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; abort = 1'b0;
    q.delete(); in_frame = 1'b0; sd_act = 1'b0; idle_chk = -1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ser_start", 32'(ser_start), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_tx_abort", 32'(tx_abort), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_id", 32'(tx_id), 0);
    chk("rst_word", 32'(ser_parallel_in), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; abort = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single request from 0; data changes after grant must not leak through
    c = cyc + 1; at_cyc(c);
    req_data[15:0] = 16'hA5C3; req_valid = 2'b01;
    push_frame(c, 0, 16'hA5C3);
    at_cyc(c + 1); req_valid = '0; req_data[15:0] = 16'hFFFF;
    at_cyc(c + SP);

    // Both held from reset: alternating grants, gap spacing
    do_reset();
    req_data = {16'hBEEF, 16'h1234};
    c = cyc + 1; at_cyc(c);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++)
      push_frame(c + k * SP, k % 2, (k % 2 == 1) ? 16'hBEEF : 16'h1234);
    at_cyc(c + 3 * SP + 1); req_valid = '0;
    at_cyc(c + 4 * SP);

    // Serial stream 0x8001 from requester 1
    c = cyc + 1; at_cyc(c);
    req_data[31:16] = 16'h8001; req_valid = 2'b10;
    push_frame(c, 1, 16'h8001);
    at_cyc(c + 1); req_valid = '0;
    at_cyc(c + SP);

    // Abort at counter 5, then abort while idle (ignored)
    c = cyc + 1; at_cyc(c);
    req_data[15:0] = 16'h0F0F; req_valid = 2'b01;
    push(EV_GRANT, c, 2'b01, 16'h0F0F, 0);
    push(EV_START, c + 1, 2'b01, 16'h0F0F, 0);
    push(EV_ABORT, c + 12, 2'b01, 16'h0F0F, 0);
    at_cyc(c + 1);  req_valid = '0;
    at_cyc(c + 12); abort = 1'b1;
    at_cyc(c + 13); abort = 1'b0;
    at_cyc(c + 14); abort = 1'b1;
    at_cyc(c + 15); abort = 1'b0;
    at_cyc(c + 17);

    // Abort held during grant (ignored), then abort at counter 0
    c = cyc + 1; at_cyc(c);
    req_data[31:16] = 16'h5AA5; req_valid = 2'b10; abort = 1'b1;
    push(EV_GRANT, c, 2'b10, 16'h5AA5, 1);
    push(EV_START, c + 1, 2'b10, 16'h5AA5, 1);
    push(EV_ABORT, c + W + 1, 2'b10, 16'h5AA5, 1);
    at_cyc(c + 1); req_valid = '0; abort = 1'b0;
    at_cyc(c + W + 1); abort = 1'b1;
    at_cyc(c + W + 2); abort = 1'b0;
    at_cyc(c + W + 4);

    // Reset mid-SHIFT after granting 0; 0 must win again afterwards
    c = cyc + 1; at_cyc(c);
    req_data[15:0] = 16'h3C3C; req_valid = 2'b01;
    push(EV_GRANT, c, 2'b01, 16'h3C3C, 0);
    push(EV_START, c + 1, 2'b01, 16'h3C3C, 0);
    at_cyc(c + 1); req_valid = '0;
    at_cyc(c + 8);
    do_reset();
    req_data = {16'h7E81, 16'hC001};
    c = cyc + 1; at_cyc(c);
    req_valid = 2'b11;
    push_frame(c, 0, 16'hC001);
    at_cyc(c + 1); req_valid = '0;
    at_cyc(c + SP + 2);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
